fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end for the five-stage MIPS pipeline. It generates the fetch PC, reads the combinational instruction memory, and buffers fetched {instruction, PC+4} pairs in a DEPTH-entry queue. The Fetch_To_Decode register drains the queue through a valid/ready handshake, so decode stalls no longer freeze the PC. Branch, jump and jr redirects flush the queue in one cycle.

## Interface
- ADDR_W, 32, PC and instruction-memory address width.
- INSTR_W, 32, instruction width.
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_PC, 0, fetch PC after reset; word aligned.
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- imem_addr  out  ADDR_W  current fetch PC, driven to the instruction memory.
- imem_rdata  in  INSTR_W  instruction at imem_addr; combinational, same cycle.
- redirect_valid  in  1  decode has resolved a taken branch, jump or jr.
- redirect_pc  in  ADDR_W  target; bits [1:0] are ignored and treated as 00.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer accepts the head this cycle.
- out_instr  out  INSTR_W  head instruction.
- out_pc_plus4  out  ADDR_W  head fetch PC + 4.
- count  out  clog2(DEPTH)+1  occupied entries.

## Operation
- Reset values: fetch PC = RESET_PC, count = 0, out_valid = 0, out_instr = 0, out_pc_plus4 = 0. Read/write pointers = 0.
- pop = out_valid & out_ready.
- push = !redirect_valid & (count < DEPTH | pop).
- On push: enqueue {imem_rdata, imem_addr+4} and set fetch PC to imem_addr+4.
- When not full, a fetch is issued every cycle.
- Redirect (priority over everything except Reset):
  - count = 0 and pointers = 0.
  - fetch PC = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - No push and no pop take effect that cycle, even if out_ready = 1.
- Full with pop: the push and the pop both happen; count is unchanged.
- Full without pop: no push; fetch PC holds and imem_addr is stable.
- Empty: out_valid = 0. out_instr and out_pc_plus4 hold the last head value; the consumer must ignore them.
- Arithmetic: PC+4 is modulo 2^ADDR_W, so 0xFFFFFFFC + 4 = 0x00000000. Pointers wrap modulo DEPTH. count never exceeds DEPTH.
- Reset mid-operation discards all entries and any pending redirect in that cycle.

## Timing
- imem_addr is registered and changes only on clock edges.
- Fetch-to-output latency is 1 cycle: an instruction pushed at edge N is visible on out_* after edge N.
- After Reset deasserts, the first fetch is at RESET_PC in the first cycle. out_valid rises after the next edge.
- Redirect penalty: redirect asserted in cycle N → imem_addr = target in cycle N+1 → target instruction on out_* in cycle N+2.
- Throughput is 1 instruction/cycle sustained with out_ready held high.
- out_* are driven from registers or the queue head with no combinational path from out_ready. count and out_valid update in the same edge as the push/pop.

## Structure
- Shared package pipeline_pkg: INSTR_W, ADDR_W, PC_STEP = 4, and RESET_PC default. The same constants are used by ProgramCounter, PCAdder and the stage registers.
- Sub-module fetch_fifo: a DEPTH×(INSTR_W+ADDR_W) circular buffer with push, pop, flush and count.
- The PC register and push/redirect logic stay in fetch_queue.
- No FSM beyond the fill state implied by count: EMPTY (0), PARTIAL, FULL (DEPTH).

## Test plan
- Reset, then out_ready=1 for 8 cycles, memory word = address → out_pc_plus4 sequence 4, 8, 12, …; out_instr 0, 4, 8, …; out_valid first high in cycle 2.
- out_ready=0 for 10 cycles:
  - count saturates at 4 and imem_addr holds at 0x10.
  - Then out_ready=1 → entries for PCs 0, 4, 8, C drain in order with no duplicates or gaps.
- Full queue with redirect_valid=1, redirect_pc=0x00000103, out_ready=1 in the same cycle:
  - Next cycle count=0 and imem_addr=0x100.
  - The following cycle out_pc_plus4=0x104; the head before the redirect was never consumed.
- RESET_PC=0xFFFFFFF8, out_ready=1 → out_pc_plus4 sequence 0xFFFFFFFC, 0x00000000, 0x00000004.
- Full queue with out_ready=1 continuously → count stays 4 and one entry is accepted every cycle.
- Reset asserted while count=3 → next cycle count=0, out_valid=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Constants shared by the fetch front end, PC logic and stage registers.
// The fetch queue's default parameter values are taken from here.
package pipeline_pkg;
    localparam int          ADDR_W   = 32;
    localparam int          INSTR_W  = 32;
    localparam int          PC_STEP  = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched entries with push, pop, flush and count.
// The head is registered, so it holds its last value while empty.
module fetch_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic          valid_o,
    output logic [DW-1:0] head_o,
    output logic [CW-1:0] count_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] remain;
    logic [DW-1:0] head_q, head_d;

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        head_d = head_q;
        remain = cnt_q - CW'(pop_i);
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + 1'b1;
            if (pop_i)  rd_d = rd_q + 1'b1;
            cnt_d = remain + CW'(push_i);
            // Head comes from the write data when it lands in an empty slot.
            if (cnt_d != '0)
                head_d = (remain == '0) ? wdata_i : mem_q[rd_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && push_i)
            mem_q[wr_q] <= wdata_i;
    end

    assign valid_o = (cnt_q != '0);
    assign head_o  = head_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch PC generation and decoupling queue in front of decode.
// Redirects flush the queue and retarget the PC in one cycle.
module fetch_queue #(
    parameter int ADDR_W  = pipeline_pkg::ADDR_W,
    parameter int INSTR_W = pipeline_pkg::INSTR_W,
    parameter int DEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(pipeline_pkg::RESET_PC),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic               Clk,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc_plus4,
    output logic [CW-1:0]      count
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic              pop;
    logic              push;
    logic              unused_rpc;

    assign unused_rpc = ^redirect_pc[1:0];
    assign pc_plus4   = pc_q + ADDR_W'(pipeline_pkg::PC_STEP);
    assign pop        = out_valid & out_ready & ~redirect_valid;
    assign push       = ~redirect_valid &
                        ((count < CW'(DEPTH)) | (out_valid & out_ready));

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid)
            pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
        else if (push)
            pc_d = pc_plus4;
    end

    always_ff @(posedge Clk) begin
        if (Reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    assign imem_addr = pc_q;

    fetch_fifo #(
        .DW    (INSTR_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .flush_i (redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({imem_rdata, pc_plus4}),
        .valid_o (out_valid),
        .head_o  ({out_instr, out_pc_plus4}),
        .count_o (count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; memory returns the address as data.
module tb_fetch_queue;
    logic        Clk;
    logic        Reset;
    logic [31:0] imem_addr, w_addr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, w_valid;
    logic        out_ready;
    logic [31:0] out_instr, w_instr;
    logic [31:0] out_pc_plus4, w_pc4;
    logic [2:0]  count, w_count;
    logic        w_ready;
    logic        w_redir;
    logic [31:0] w_rpc;
    int n_cmp;
    int n_err;

    fetch_queue u_dut (
        .Clk(Clk), .Reset(Reset),
        .imem_addr(imem_addr), .imem_rdata(imem_addr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc_plus4(out_pc_plus4),
        .count(count)
    );

    fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .Clk(Clk), .Reset(Reset),
        .imem_addr(w_addr), .imem_rdata(w_addr),
        .redirect_valid(w_redir), .redirect_pc(w_rpc),
        .out_valid(w_valid), .out_ready(w_ready),
        .out_instr(w_instr), .out_pc_plus4(w_pc4),
        .count(w_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        do_reset();
        n_cmp++;
        if (count !== 3'd0) begin
            n_err++; $display("FAIL reset_count got %0d want 0", count);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid got %b want 0", out_valid);
        end
        n_cmp++;
        if (imem_addr !== 32'h0) begin
            n_err++; $display("FAIL reset_addr got %h want 0", imem_addr);
        end
        n_cmp++;
        if ({out_instr, out_pc_plus4} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_out got %h/%h want 0/0", out_instr, out_pc_plus4);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc_plus4 !== 32'(4 * (i + 1)) ||
                out_instr !== 32'(4 * i) || count !== 3'd1) begin
                n_err++;
                $display("FAIL stream[%0d] got v=%b pc4=%h in=%h c=%0d want v=1 pc4=%h in=%h c=1",
                         i, out_valid, out_pc_plus4, out_instr, count,
                         32'(4 * (i + 1)), 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall_drain();
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) step();
        n_cmp++;
        if (count !== 3'd4) begin
            n_err++; $display("FAIL stall_count got %0d want 4", count);
        end
        n_cmp++;
        if (imem_addr !== 32'h10) begin
            n_err++; $display("FAIL stall_addr got %h want 10", imem_addr);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_instr !== 32'(4 * i) ||
                out_pc_plus4 !== 32'(4 * i + 4)) begin
                n_err++;
                $display("FAIL drain[%0d] got v=%b in=%h pc4=%h want v=1 in=%h pc4=%h",
                         i, out_valid, out_instr, out_pc_plus4,
                         32'(4 * i), 32'(4 * i + 4));
            end
            step();
        end
    endtask

    task automatic test_redirect();
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        out_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        n_cmp++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL redir_flush got c=%0d v=%b want c=0 v=0", count, out_valid);
        end
        n_cmp++;
        if (imem_addr !== 32'h100) begin
            n_err++; $display("FAIL redir_addr got %h want 100", imem_addr);
        end
        n_cmp++;
        if (out_pc_plus4 !== 32'h4) begin
            n_err++; $display("FAIL redir_hold got %h want 4", out_pc_plus4);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc_plus4 !== 32'h104 ||
            out_instr !== 32'h100 || count !== 3'd1) begin
            n_err++;
            $display("FAIL redir_target got v=%b pc4=%h in=%h c=%0d want v=1 pc4=104 in=100 c=1",
                     out_valid, out_pc_plus4, out_instr, count);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [3];
        exp[0] = 32'hFFFF_FFFC;
        exp[1] = 32'h0000_0000;
        exp[2] = 32'h0000_0004;
        out_ready = 1'b1;
        do_reset();
        n_cmp++;
        if (w_addr !== 32'hFFFF_FFF8) begin
            n_err++; $display("FAIL wrap_reset_addr got %h want fffffff8", w_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (w_valid !== 1'b1 || w_pc4 !== exp[i]) begin
                n_err++;
                $display("FAIL wrap[%0d] got v=%b pc4=%h want v=1 pc4=%h",
                         i, w_valid, w_pc4, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (out_pc_plus4 !== 32'(4 * (i + 1))) begin
                n_err++;
                $display("FAIL b2b_head[%0d] got %h want %h",
                         i, out_pc_plus4, 32'(4 * (i + 1)));
            end
            step();
            n_cmp++;
            if (count !== 3'd4) begin
                n_err++; $display("FAIL b2b_count[%0d] got %0d want 4", i, count);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (count !== 3'd3) begin
            n_err++; $display("FAIL mid_pre_count got %0d want 3", count);
        end
        Reset = 1'b1;
        step();
        n_cmp++;
        if (count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 32'h0 ||
            out_pc_plus4 !== 32'h0) begin
            n_err++;
            $display("FAIL mid_reset got c=%0d v=%b a=%h pc4=%h want 0/0/0/0",
                     count, out_valid, imem_addr, out_pc_plus4);
        end
        Reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Reset = 1'b1;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        w_ready = 1'b1;
        w_redir = 1'b0;
        w_rpc = '0;
        test_reset();
        test_stream();
        test_stall_drain();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
